serial_to_parallel: RTL and testbench
=====================================

# serial_to_parallel

Parametrised serial-to-parallel converter. It collects single-bit samples from a serial stream into WIDTH-bit words and presents each completed word on a valid/ready output port. It supports:
- selectable bit order;
- a per-bit enable;
- a sync input that realigns word boundaries;
- backpressure with overflow reporting.

It sits between the bit-level capture logic and the word-level correlator datapath, and replaces the fixed 3-bit shifter.

## Interface
- WIDTH, 3: bits per output word; legal range 1..64.
- MSB_FIRST, 1: 1 = first received bit lands in out[WIDTH-1]; 0 = first received bit lands in out[0].
- clk  input  1  sole clock; all state changes on rising edge.
- rst  input  1  reset, synchronous and active-high.
- in  input  1  serial data bit.
- in_valid  input  1  bit enable; `in` is accepted only on edges where in_valid=1.
- sync  input  1  frame marker; qualified by in_valid; marks the accepted bit as bit 0 of a new word.
- out  output  WIDTH  completed word; stable while out_valid=1.
- out_valid  output  1  word available.
- out_ready  input  1  consumer accepts word on edges where out_valid=1 and out_ready=1.
- busy  output  1  1 when a partial word is held (bit counter != 0).
- overflow  output  1  sticky; set when a completed word is dropped.
- clr_ovf  input  1  clears overflow.

## Operation
- State:
  - collect register (WIDTH bits);
  - bit counter 0..WIDTH-1, width $clog2(WIDTH+1);
  - output register with valid flag;
  - overflow flag.
- Bit accept (in_valid=1, sync=0): store `in` at position cnt (MSB_FIRST=1: index WIDTH-1-cnt; else index cnt), then cnt <= cnt+1.
- Bit accept with sync=1:
  - discard any partial word;
  - store `in` as bit 0 of a new word; cnt <= 1.
  - busy stays 1 unless the word completes on this bit.
- Word complete: the accepted bit is bit WIDTH-1 (includes a sync bit when WIDTH=1).
  - The assembled word, including the current bit, is the candidate; cnt <= 0.
  - Collect register need not be cleared; unwritten positions are always overwritten before the next completion.
- Output slot, on completion:
  - Slot empty, or consumed on the same edge (out_valid & out_ready): out <= candidate, out_valid <= 1.
  - Slot full and out_ready=0: candidate dropped, out/out_valid unchanged, overflow <= 1.
- Output slot without completion: out_valid & out_ready -> out_valid <= 0; out holds its last value.
- out_ready while out_valid=0: ignored.
- in_valid=0: no state change in the collector. sync and in are ignored.
- Overflow:
  - clr_ovf=1 clears overflow.
  - If a drop occurs on the same edge as clr_ovf, set wins: overflow=1.
- Reset values: out=0, out_valid=0, overflow=0, busy=0, cnt=0, collect register=0.
- Reset mid-word discards the partial word and any pending output. rst overrides all other inputs.

## Timing
- Bit accepted at edge E updates internal state at E.
- Latency: word completed at edge E -> out/out_valid visible in the cycle after E (1 cycle; no combinational path from `in` to out/out_valid).
- Throughput:
  - One bit per clock with in_valid held high.
  - One word per WIDTH cycles. This needs out_ready=1 on each edge where a new word completes while out_valid=1.
- out is registered; it changes only on an edge that loads a new word, or on reset.
- busy is registered, derived from cnt.
- overflow changes at the drop edge. There is no pulse output.

## Test plan
- WIDTH=3, MSB_FIRST=1, out_ready=1:
  - Stimulus: bits 1,1,0 on three consecutive edges with in_valid=1.
  - Required: out=3'b110 and out_valid=1 in the cycle after edge 3; out_valid=0 in the following cycle; busy=1 after edges 1–2, 0 after edge 3.
- MSB_FIRST=0, same stimulus -> out=3'b011. Repeat with in_valid=0 gaps of 2 cycles between bits -> identical word; out_valid timing follows the third accepted bit.
- Sync realign, WIDTH=3, MSB_FIRST=1:
  - Stimulus: bits 1,1 accepted, then sync=1 with bit 0, then bits 1,1.
  - Required: out=3'b011; no word emitted for the discarded partial word.
- Backpressure, WIDTH=3, out_ready=0:
  - Stimulus: stream 101, then 010.
  - Required: out stays 3'b101 with out_valid=1; overflow=1 after the 6th bit.
  - Then raise out_ready for 1 cycle -> out_valid=0.
  - Then clr_ovf=1 -> overflow=0.
  - Simultaneous case: 3rd bit of a word with out_valid=1 and out_ready=1 -> new word loaded, out_valid stays 1, no overflow.
- Reset mid-operation:
  - Stimulus: assert rst after 2 bits with a word pending and overflow=1.
  - Required next cycle: out=0, out_valid=0, overflow=0, busy=0; the next 3 bits 1,0,1 produce out=3'b101.
- WIDTH=1 and WIDTH=64, random bit stream with random in_valid/out_ready:
  - A scoreboard must match every accepted word.
  - Every drop must coincide with overflow being set.

Source files
------------

// File: rtl/serial_to_parallel.sv
// Serial-to-parallel converter: assembles WIDTH-bit words from a bit stream and
// offers them on a single-entry valid/ready output slot with sticky overflow.
module serial_to_parallel #(
    parameter int unsigned WIDTH     = 3,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in,
    input  logic             in_valid,
    input  logic             sync,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             overflow,
    input  logic             clr_ovf
);

    localparam int unsigned    CntW    = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    logic [CntW-1:0]  cnt_q, cnt_d, pos;
    logic [WIDTH-1:0] collect_q, collect_d, candidate;
    logic [WIDTH-1:0] out_q, out_d;
    logic             out_valid_q, out_valid_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             complete, consume;

    always_comb begin
        // A sync bit always lands in the first position of a fresh word.
        pos       = sync ? '0 : cnt_q;
        candidate = collect_q;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (CntW'(MSB_FIRST ? (WIDTH - 1 - i) : i) == pos) begin
                candidate[i] = in;
            end
        end
        complete  = in_valid && (pos == LastCnt);
        consume   = out_valid_q && out_ready;

        collect_d = in_valid ? candidate : collect_q;
        cnt_d     = cnt_q;
        if (in_valid) begin
            cnt_d = complete ? '0 : pos + CntW'(1);
        end
        busy_d = (cnt_d != '0);

        out_d       = out_q;
        out_valid_d = out_valid_q;
        ovf_d       = clr_ovf ? 1'b0 : ovf_q;
        if (complete) begin
            if (!out_valid_q || out_ready) begin
                out_d       = candidate;
                out_valid_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end else if (consume) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            collect_q   <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            collect_q   <= collect_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            ovf_q       <= ovf_d;
            busy_q      <= busy_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign overflow  = ovf_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_serial_to_parallel.sv
// Bench for serial_to_parallel: directed cases on two WIDTH=3 instances (both bit
// orders) and a scoreboard-checked random stream on WIDTH=1 and WIDTH=64 instances.
module tb_serial_to_parallel;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    // Directed stimulus, shared by both WIDTH=3 instances.
    logic       d_in, d_iv, d_sync, d_rdy, d_clr;
    logic [2:0] a_out, b_out;
    logic       a_valid, a_busy, a_ovf, b_valid, b_busy, b_ovf;

    // Random stimulus: index 0 -> WIDTH=1 MSB-first, index 1 -> WIDTH=64 LSB-first.
    logic        r_in [2];
    logic        r_iv [2];
    logic        r_rdy [2];
    logic        r_clr [2];
    logic        r_valid [2];
    logic        r_busy [2];
    logic        r_ovf [2];
    logic [0:0]  o1;
    logic [63:0] o64;
    logic        r_sync0, r_sync1;

    serial_to_parallel #(.WIDTH(3), .MSB_FIRST(1'b1)) u_a (
        .clk(clk), .rst(rst), .in(d_in), .in_valid(d_iv), .sync(d_sync),
        .out(a_out), .out_valid(a_valid), .out_ready(d_rdy), .busy(a_busy),
        .overflow(a_ovf), .clr_ovf(d_clr)
    );

    serial_to_parallel #(.WIDTH(3), .MSB_FIRST(1'b0)) u_b (
        .clk(clk), .rst(rst), .in(d_in), .in_valid(d_iv), .sync(d_sync),
        .out(b_out), .out_valid(b_valid), .out_ready(d_rdy), .busy(b_busy),
        .overflow(b_ovf), .clr_ovf(d_clr)
    );

    serial_to_parallel #(.WIDTH(1), .MSB_FIRST(1'b1)) u_w1 (
        .clk(clk), .rst(rst), .in(r_in[0]), .in_valid(r_iv[0]), .sync(r_sync0),
        .out(o1), .out_valid(r_valid[0]), .out_ready(r_rdy[0]), .busy(r_busy[0]),
        .overflow(r_ovf[0]), .clr_ovf(r_clr[0])
    );

    serial_to_parallel #(.WIDTH(64), .MSB_FIRST(1'b0)) u_w64 (
        .clk(clk), .rst(rst), .in(r_in[1]), .in_valid(r_iv[1]), .sync(r_sync1),
        .out(o64), .out_valid(r_valid[1]), .out_ready(r_rdy[1]), .busy(r_busy[1]),
        .overflow(r_ovf[1]), .clr_ovf(r_clr[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One directed cycle: drive after a falling edge, return at the next falling edge.
    task automatic step(input logic b, input logic iv, input logic sy, input logic clr);
        d_in   = b;
        d_iv   = iv;
        d_sync = sy;
        d_clr  = clr;
        @(posedge clk);
        @(negedge clk);
        d_in   = 1'b0;
        d_iv   = 1'b0;
        d_sync = 1'b0;
        d_clr  = 1'b0;
    endtask

    task automatic bit_in(input logic b);
        step(b, 1'b1, 1'b0, 1'b0);
    endtask

    // Idle cycles present in/sync as 1 to show they are ignored without in_valid.
    task automatic idle();
        step(1'b1, 1'b0, 1'b1, 1'b0);
    endtask

    // Scoreboard and reference model for the random phase.
    logic [63:0] exp_q0[$];
    logic [63:0] exp_q1[$];
    logic [63:0] m_word [2];
    int          m_cnt [2];
    logic        m_valid [2];
    logic        m_ovf [2];

    initial begin
        rst = 1'b1;
        d_in = 1'b0; d_iv = 1'b0; d_sync = 1'b0; d_rdy = 1'b0; d_clr = 1'b0;
        r_sync0 = 1'b0;
        r_sync1 = 1'b0;
        for (int k = 0; k < 2; k++) begin
            r_in[k] = 1'b0; r_iv[k] = 1'b0; r_rdy[k] = 1'b0; r_clr[k] = 1'b0;
            m_word[k] = '0; m_cnt[k] = 0; m_valid[k] = 1'b0; m_ovf[k] = 1'b0;
        end
        @(negedge clk);
        idle();
        idle();
        rst = 1'b0;
        chk("reset_out", 64'(a_out), 64'h0);
        chk("reset_valid", 64'(a_valid), 64'h0);
        chk("reset_busy", 64'(a_busy), 64'h0);
        chk("reset_ovf", 64'(a_ovf), 64'h0);

        // Basic word, both bit orders.
        d_rdy = 1'b1;
        bit_in(1'b1);
        chk("basic_busy1", 64'(a_busy), 64'h1);
        chk("basic_valid1", 64'(a_valid), 64'h0);
        bit_in(1'b1);
        chk("basic_busy2", 64'(a_busy), 64'h1);
        bit_in(1'b0);
        chk("basic_msb_out", 64'(a_out), 64'h6);
        chk("basic_lsb_out", 64'(b_out), 64'h3);
        chk("basic_valid3", 64'(a_valid), 64'h1);
        chk("basic_busy3", 64'(a_busy), 64'h0);
        idle();
        chk("basic_drained", 64'(a_valid), 64'h0);
        chk("basic_hold", 64'(a_out), 64'h6);

        // Same word with in_valid gaps.
        bit_in(1'b1);
        idle();
        idle();
        chk("gap_busy", 64'(a_busy), 64'h1);
        bit_in(1'b1);
        idle();
        idle();
        chk("gap_novalid", 64'(a_valid), 64'h0);
        bit_in(1'b0);
        chk("gap_msb_out", 64'(a_out), 64'h6);
        chk("gap_lsb_out", 64'(b_out), 64'h3);
        chk("gap_valid", 64'(a_valid), 64'h1);
        idle();

        // Sync realigns: 1,1 discarded, then 0(sync),1,1.
        bit_in(1'b1);
        bit_in(1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        chk("sync_novalid", 64'(a_valid), 64'h0);
        chk("sync_busy", 64'(a_busy), 64'h1);
        bit_in(1'b1);
        chk("sync_novalid2", 64'(a_valid), 64'h0);
        bit_in(1'b1);
        chk("sync_msb_out", 64'(a_out), 64'h3);
        chk("sync_lsb_out", 64'(b_out), 64'h6);
        chk("sync_valid", 64'(a_valid), 64'h1);
        idle();

        // Backpressure and overflow.
        d_rdy = 1'b0;
        bit_in(1'b1); bit_in(1'b0); bit_in(1'b1);
        bit_in(1'b0); bit_in(1'b1); bit_in(1'b0);
        chk("bp_out", 64'(a_out), 64'h5);
        chk("bp_lsb_out", 64'(b_out), 64'h5);
        chk("bp_valid", 64'(a_valid), 64'h1);
        chk("bp_ovf", 64'(a_ovf), 64'h1);
        d_rdy = 1'b1;
        idle();
        d_rdy = 1'b0;
        chk("bp_drain", 64'(a_valid), 64'h0);
        chk("bp_ovf_sticky", 64'(a_ovf), 64'h1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("bp_clr", 64'(a_ovf), 64'h0);

        // Consume and load on the same edge.
        bit_in(1'b1); bit_in(1'b1); bit_in(1'b1);
        chk("sim_first", 64'(a_out), 64'h7);
        bit_in(1'b0); bit_in(1'b0);
        d_rdy = 1'b1;
        bit_in(1'b1);
        d_rdy = 1'b0;
        chk("sim_msb_out", 64'(a_out), 64'h1);
        chk("sim_lsb_out", 64'(b_out), 64'h4);
        chk("sim_valid", 64'(a_valid), 64'h1);
        chk("sim_ovf", 64'(a_ovf), 64'h0);

        // Drop on the same edge as clr_ovf: set wins.
        bit_in(1'b1); bit_in(1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        chk("setwins_ovf", 64'(a_ovf), 64'h1);
        chk("setwins_out", 64'(a_out), 64'h1);

        // Reset mid-word with a pending word and overflow set.
        bit_in(1'b1); bit_in(1'b1);
        chk("rstmid_busy", 64'(a_busy), 64'h1);
        rst = 1'b1;
        idle();
        rst = 1'b0;
        chk("rstmid_out", 64'(a_out), 64'h0);
        chk("rstmid_valid", 64'(a_valid), 64'h0);
        chk("rstmid_ovf", 64'(a_ovf), 64'h0);
        chk("rstmid_busy0", 64'(a_busy), 64'h0);
        d_rdy = 1'b1;
        bit_in(1'b1); bit_in(1'b0); bit_in(1'b1);
        chk("rstmid_msb_out", 64'(a_out), 64'h5);
        chk("rstmid_lsb_out", 64'(b_out), 64'h5);
        chk("rstmid_valid1", 64'(a_valid), 64'h1);

        // Random streams on WIDTH=1 and WIDTH=64 against the scoreboard.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int k = 0; k < 2; k++) begin
                int          w;
                int          p;
                logic        consume;
                logic        complete;
                logic [63:0] obs;
                logic [63:0] exp_w;
                w   = (k == 0) ? 1 : 64;
                obs = (k == 0) ? {63'h0, o1} : o64;
                chk("rnd_valid", 64'(r_valid[k]), 64'(m_valid[k]));
                chk("rnd_ovf", 64'(r_ovf[k]), 64'(m_ovf[k]));
                chk("rnd_busy", 64'(r_busy[k]), 64'(m_cnt[k] != 0));

                r_iv[k]  = ($urandom_range(0, 3) != 0);
                r_in[k]  = 1'($urandom_range(0, 1));
                r_rdy[k] = (k == 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 15) == 0);
                r_clr[k] = ($urandom_range(0, 31) == 0);

                consume = m_valid[k] && r_rdy[k];
                if (consume) begin
                    if (k == 0) begin
                        chk("rnd_q_nonempty", 64'(exp_q0.size() != 0), 64'h1);
                        exp_w = (exp_q0.size() != 0) ? exp_q0.pop_front() : 64'h0;
                    end else begin
                        chk("rnd_q_nonempty", 64'(exp_q1.size() != 0), 64'h1);
                        exp_w = (exp_q1.size() != 0) ? exp_q1.pop_front() : 64'h0;
                    end
                    chk((k == 0) ? "rnd_word_w1" : "rnd_word_w64", obs, exp_w);
                end
                complete = 1'b0;
                if (r_iv[k]) begin
                    p = (k == 0) ? (w - 1 - m_cnt[k]) : m_cnt[k];
                    m_word[k][p] = r_in[k];
                    m_cnt[k]++;
                    if (m_cnt[k] == w) begin
                        complete = 1'b1;
                        m_cnt[k] = 0;
                    end
                end
                if (r_clr[k]) m_ovf[k] = 1'b0;
                if (complete) begin
                    if (!m_valid[k] || r_rdy[k]) begin
                        exp_w = (k == 0) ? {63'h0, m_word[k][0]} : m_word[k];
                        if (k == 0) exp_q0.push_back(exp_w);
                        else exp_q1.push_back(exp_w);
                        m_valid[k] = 1'b1;
                    end else begin
                        m_ovf[k] = 1'b1;
                    end
                end else if (consume) begin
                    m_valid[k] = 1'b0;
                end
            end
            @(posedge clk);
            @(negedge clk);
        end
        for (int k = 0; k < 2; k++) begin
            chk("rnd_final_valid", 64'(r_valid[k]), 64'(m_valid[k]));
            chk("rnd_final_ovf", 64'(r_ovf[k]), 64'(m_ovf[k]));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
